// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - round-robin arbiter sharing one APB master port among NREQ requesters
// Optional ACCESS watchdog (req_err on PREADY timeout): define APB_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module apb_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_grant,
  output logic [NREQ-1:0]    req_done,
  output logic [DW-1:0]      req_rdata,
  output logic               req_err,
  output logic               PSEL,
  output logic               transfer,
  output logic               PWRITE,
  output logic [AW-1:0]      PADDR,
  output logic [DW-1:0]      PDATA,
  input  logic               PREADY,
  input  logic [DW-1:0]      PRDATA
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [PW-1:0]   w_win, w_idx;
  logic            w_any;
  logic            w_timeout;
  logic            w_finish;

  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic [DW-1:0]   r_rdata, w_rdata_nxt;
  logic            r_err, w_err_nxt;
  logic            r_psel, w_psel_nxt;
  logic            r_transfer, w_transfer_nxt;
  logic            r_pwrite, w_pwrite_nxt;
  logic [AW-1:0]   r_paddr, w_paddr_nxt;
  logic [DW-1:0]   r_pdata, w_pdata_nxt;

  // Round-robin pick: first valid requester at ptr+1, ptr+2, ... wrapping at NREQ.
  // Walking from the farthest candidate back lets the nearest one win last.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  // Count PREADY-low ACCESS cycles; cleared on the way into ACCESS.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_cnt <= '0;
    end else if (r_state == S_ACCESS && !PREADY) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && !PREADY && (r_cnt == CW'(TIMEOUT - 1));
`else
  // No watchdog: ACCESS waits for PREADY indefinitely and TIMEOUT has no effect.
  assign w_timeout = 1'b0;
  if (TIMEOUT < 1) begin : g_no_watchdog
  end
`endif

  assign w_finish = (r_state == S_ACCESS) && (PREADY || w_timeout);

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: SETUP and DONE last one cycle, ACCESS waits for completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_finish) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; payload is only sampled at grant.
  always_comb begin
    w_ptr_nxt      = r_ptr;
    w_grant_nxt    = r_grant;
    w_done_nxt     = '0;
    w_rdata_nxt    = r_rdata;
    w_err_nxt      = 1'b0;
    w_psel_nxt     = r_psel;
    w_transfer_nxt = r_transfer;
    w_pwrite_nxt   = r_pwrite;
    w_paddr_nxt    = r_paddr;
    w_pdata_nxt    = r_pdata;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_ptr_nxt          = w_win;
          w_grant_nxt        = '0;
          w_grant_nxt[w_win] = 1'b1;
          w_psel_nxt         = 1'b1;
          w_transfer_nxt     = 1'b1;
          w_pwrite_nxt       = req_write[w_win];
          w_paddr_nxt        = req_addr[int'(w_win)*AW +: AW];
          w_pdata_nxt        = req_wdata[int'(w_win)*DW +: DW];
        end
      end
      S_ACCESS: begin
        if (w_finish) begin
          w_done_nxt[r_ptr] = 1'b1;
          w_psel_nxt        = 1'b0;
          w_transfer_nxt    = 1'b0;
          if (w_timeout) begin
            w_err_nxt   = 1'b1;
            w_rdata_nxt = '0;
          end else if (!r_pwrite) begin
            w_rdata_nxt = PRDATA;
          end
        end
      end
      S_DONE: begin
        w_grant_nxt = '0;
      end
      default: begin
      end
    endcase
  end

  // Output and pointer registers; ptr restarts at NREQ-1 so requester 0 wins first.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ptr      <= PW'(NREQ - 1);
      r_grant    <= '0;
      r_done     <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_psel     <= 1'b0;
      r_transfer <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pdata    <= '0;
    end else begin
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_rdata    <= w_rdata_nxt;
      r_err      <= w_err_nxt;
      r_psel     <= w_psel_nxt;
      r_transfer <= w_transfer_nxt;
      r_pwrite   <= w_pwrite_nxt;
      r_paddr    <= w_paddr_nxt;
      r_pdata    <= w_pdata_nxt;
    end
  end

  assign req_grant = r_grant;
  assign req_done  = r_done;
  assign req_rdata = r_rdata;
  assign req_err   = r_err;
  assign PSEL      = r_psel;
  assign transfer  = r_transfer;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PDATA     = r_pdata;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - randomized scoreboard bench for apb_arbiter
`timescale 1ns/1ps
module tb_apb_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic               PCLK = 1'b0;
  logic               PRESETn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_grant;
  logic [NREQ-1:0]    req_done;
  logic [DW-1:0]      req_rdata;
  logic               req_err;
  logic               PSEL;
  logic               transfer;
  logic               PWRITE;
  logic [AW-1:0]      PADDR;
  logic [DW-1:0]      PDATA;
  logic               PREADY;
  logic [DW-1:0]      PRDATA;

  apb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
    .PSEL(PSEL), .transfer(transfer), .PWRITE(PWRITE), .PADDR(PADDR), .PDATA(PDATA),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    int              idx;
    bit              wr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    bit              err;
    int              lat;
    int              gap;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err    = 0;

  // Reference state: last granted index and the value req_rdata should hold.
  int            model_ptr   = NREQ - 1;
  logic [DW-1:0] model_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_wait(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got no DUT event within bound, required one", name);
  endtask

  // Predict the winner from the round-robin rule and queue its expected completion.
  task automatic expect_txn(input int w, input int gap, output int win);
    exp_t e;
    int   j;
    bit   abort;
    win   = -1;
    abort = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (model_ptr + k) % NREQ;
      if (win < 0 && req_valid[j]) win = j;
    end
    if (win < 0) return;
    e.idx   = win;
    e.wr    = req_write[win];
    e.addr  = req_addr[win*AW +: AW];
    e.wdata = req_wdata[win*DW +: DW];
    e.gap   = gap;
    e.err   = 1'b0;
    e.lat   = 2 + w;
`ifdef APB_ARB_TIMEOUT_EN
    abort = (w >= TIMEOUT);
`endif
    if (abort) begin
      e.err       = 1'b1;
      e.lat       = 1 + TIMEOUT;
      model_rdata = '0;
    end else if (!e.wr) begin
      model_rdata = PRDATA;
    end
    e.rdata   = model_rdata;
    model_ptr = win;
    sb.push_back(e);
  endtask

  // Drive one transaction: w PREADY-low cycles; hold keeps all req_valid bits up.
  task automatic run(input int w, input bit hold, input int gap, input logic [DW-1:0] prd);
    int win;
    int to;
    PRDATA = prd;
    expect_txn(w, gap, win);
    if (win < 0) return;
    to = 0;
    while (req_grant != '0 && to < 20) begin @(negedge PCLK); to++; end
    to = 0;
    while (req_grant == '0 && to < 20) begin @(negedge PCLK); to++; end
    if (req_grant == '0) begin
      fail_wait("grant_wait");
      sb.delete();
      return;
    end
    PREADY = 1'b0;
    @(negedge PCLK);
    if (!hold) begin
      req_valid                = '0;
      req_addr[win*AW +: AW]   = $urandom;
      req_wdata[win*DW +: DW]  = $urandom;
      req_write[win]           = ~req_write[win];
    end
    PREADY = (w == 0);
    for (int i = 1; i <= w && req_done == '0; i++) begin
      @(negedge PCLK);
`ifndef APB_ARB_TIMEOUT_EN
      if (i == 100) begin
        chk("stall_psel", PSEL, 1);
        chk("stall_no_done", req_done, 0);
      end
`endif
      PREADY = (i == w);
    end
    to = 0;
    while (req_done == '0 && to < 300) begin @(negedge PCLK); to++; end
    if (req_done == '0) begin
      fail_wait("done_wait");
      sb.delete();
    end
    PREADY = 1'b0;
  endtask

  // Monitor: check grant-time bus values against the queue head, pop on req_done.
  logic [NREQ-1:0] m_prev_grant = '0;
  int              m_grant_cyc  = 0;
  exp_t            m_e;
  always @(negedge PCLK) begin
    if (req_grant != '0 && m_prev_grant == '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant", req_grant, 0);
      end else begin
        m_e = sb[0];
        chk("grant_onehot", req_grant, 64'(1) << m_e.idx);
        chk("grant_paddr", PADDR, m_e.addr);
        chk("grant_pdata", PDATA, m_e.wdata);
        chk("grant_pwrite", PWRITE, m_e.wr);
        chk("grant_psel", PSEL, 1);
        chk("grant_transfer", transfer, 1);
        if (m_e.gap != 0) chk("grant_gap", cyc - m_grant_cyc, m_e.gap);
      end
      m_grant_cyc <= cyc;
    end
    if (req_done != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", req_done, 0);
      end else begin
        m_e = sb.pop_front();
        chk("done_onehot", req_done, 64'(1) << m_e.idx);
        chk("done_rdata", req_rdata, m_e.rdata);
        chk("done_err", req_err, m_e.err);
        chk("done_latency", cyc - m_grant_cyc, m_e.lat);
        chk("done_psel", PSEL, 0);
        chk("done_transfer", transfer, 0);
        chk("done_paddr_held", PADDR, m_e.addr);
        chk("done_grant_held", req_grant, 64'(1) << m_e.idx);
      end
    end
    m_prev_grant <= req_grant;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, req_grant, 0);
    chk({tag, "_done"}, req_done, 0);
    chk({tag, "_rdata"}, req_rdata, 0);
    chk({tag, "_err"}, req_err, 0);
    chk({tag, "_psel"}, PSEL, 0);
    chk({tag, "_transfer"}, transfer, 0);
    chk({tag, "_pwrite"}, PWRITE, 0);
    chk({tag, "_paddr"}, PADDR, 0);
    chk({tag, "_pdata"}, PDATA, 0);
  endtask

  initial begin
    int win;
    int to;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PRESETn   = 1'b1;
    #2 PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    chk_all_zero("reset");
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Single write from requester 1
    req_valid                = 4'b0010;
    req_write[1]             = 1'b1;
    req_addr[1*AW +: AW]     = 32'h0000_0010;
    req_wdata[1*DW +: DW]    = 32'hDEAD_BEEF;
    run(0, 1'b0, 0, 32'h0);

    // Read from requester 2 with three wait states
    req_valid                = 4'b0100;
    req_write[2]             = 1'b0;
    req_addr[2*AW +: AW]     = 32'h0000_0020;
    run(3, 1'b0, 0, 32'h1234_5678);

    // Reset asserted mid-ACCESS: asynchronous clear, no completion, no re-service
    req_valid                = 4'b0001;
    req_write[0]             = 1'b0;
    req_addr[0*AW +: AW]     = 32'h0000_0030;
    PRDATA                   = 32'hCAFE_F00D;
    expect_txn(50, 0, win);
    to = 0;
    while (req_grant == '0 && to < 20) begin @(negedge PCLK); to++; end
    if (req_grant == '0) fail_wait("rst_grant_wait");
    PREADY    = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge PCLK);
    #1 PRESETn = 1'b0;
    #1;
    chk_all_zero("rst_async");
    sb.delete();
    model_ptr   = NREQ - 1;
    model_rdata = '0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (8) @(negedge PCLK);
    chk("rst_no_regrant", req_grant, 0);

    // Fairness: all requesters held valid -> 0,1,2,3,0 one grant every 4 cycles
    for (int i = 0; i < NREQ; i++) begin
      req_write[i]          = i[0];
      req_addr[i*AW +: AW]  = 32'h100 + 32'(i * 4);
      req_wdata[i*DW +: DW] = $urandom;
    end
    req_valid = '1;
    for (int t = 0; t < 5; t++) run(0, t < 4, (t == 0) ? 0 : 4, $urandom);

    // Withdrawal: requester 3 served once, then drops while requester 0 is in ACCESS
    req_valid             = 4'b1000;
    req_write[3]          = 1'b1;
    run(0, 1'b0, 0, $urandom);
    req_valid             = 4'b1001;
    req_write[0]          = 1'b0;
    req_addr[0*AW +: AW]  = 32'h0000_0040;
    run(1, 1'b0, 0, 32'h5A5A_A5A5);
    repeat (12) @(negedge PCLK);
    chk("withdraw_no_grant", req_grant, 0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_write[i]          = $urandom_range(0, 1);
        req_addr[i*AW +: AW]  = $urandom;
        req_wdata[i*DW +: DW] = $urandom;
      end
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run($urandom_range(0, 4), 1'b0, 0, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end

    // Long PREADY stall: aborts after TIMEOUT with the watchdog, waits otherwise
    req_valid             = 4'b0010;
    req_write[1]          = 1'b0;
    req_addr[1*AW +: AW]  = 32'h0000_0050;
    run(120, 1'b0, 0, 32'h0BAD_0BAD);
    repeat (4) @(negedge PCLK);
    chk("final_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    fail_wait("global_watchdog");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Round-robin scheduler that shares the single APB master port between `NREQ` independent requesters. It accepts one read or write request at a time and latches its address and data. It then drives the master's select, transfer, direction, address and data inputs through the setup and access phases, and returns read data plus a one-cycle completion pulse to the winning requester. It sits directly in front of the APB master in the bus subsystem.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 16, PREADY-low cycles tolerated in ACCESS before abort (used only with `APB_ARB_TIMEOUT_EN`)

Clock and reset: one clock, `PCLK`. Reset is `PRESETn`: asynchronous, active-low.

- `PCLK` in 1, clock; all logic on the rising edge
- `PRESETn` in 1, asynchronous active-low reset
- `req_valid` in NREQ, per-requester request
- `req_write` in NREQ, per-requester direction; 1 = write
- `req_addr` in NREQ*AW, packed addresses; requester i at [i*AW +: AW]
- `req_wdata` in NREQ*DW, packed write data; requester i at [i*DW +: DW]
- `req_grant` out NREQ, one-hot; high from SETUP through DONE
- `req_done` out NREQ, one-cycle completion pulse to the granted requester
- `req_rdata` out DW, read data; valid with `req_done`; holds until the next completion
- `req_err` out 1, timeout flag; valid with `req_done`
- `PSEL` out 1, to master
- `transfer` out 1, to master
- `PWRITE` out 1, to master
- `PADDR` out AW, to master
- `PDATA` out DW, to master
- `PREADY` in 1, from bus
- `PRDATA` in DW, from bus

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- **IDLE**
  - If any `req_valid` bit is set, select the winner round-robin: search from `ptr+1` upward, wrapping at NREQ.
  - Latch the winner's `req_write`, `req_addr` and `req_wdata` into `PWRITE`, `PADDR` and `PDATA`.
  - Set `ptr` to the winner, set `req_grant[winner]`, and assert `PSEL` and `transfer`.
  - Go to SETUP.
- **SETUP**: one cycle, unconditional; go to ACCESS.
- **ACCESS**
  - While `PREADY`=0, hold all outputs.
  - On the first edge with `PREADY`=1:
    - Capture `req_rdata` <= `PRDATA` on reads; on writes `req_rdata` is unchanged.
    - Pulse `req_done[winner]`, with `req_err`=0.
    - Deassert `PSEL` and `transfer`, and go to DONE.
- **DONE**: one cycle; clear `req_grant` and go to IDLE.
- Payload is sampled only at grant. Changes to `req_*` from a granted requester are ignored until its `req_done`.
- A requester that drops `req_valid` before being granted is withdrawn; no transfer is issued for it.
- The requester must clear `req_valid` in its `req_done` cycle. A `req_valid` still high when the arbiter returns to IDLE is treated as a new request.
- `ptr` is only ever NREQ-1 (after reset) or a granted index.

## Timing
- Reset values (asynchronous):
  - `req_grant`, `req_done`, `req_rdata`, `req_err`, `PSEL`, `transfer`, `PWRITE`, `PADDR`, `PDATA` all 0.
  - State is IDLE, and `ptr` = NREQ-1, so requester 0 wins first.
- Minimum transaction, with `req_valid` sampled at edge E and `PREADY`=1:
  - E: grant, `PSEL`=1.
  - E+1: ACCESS.
  - E+2: `req_done`, `PSEL`=0.
  - E+3: IDLE.
  - E+4: next grant.
  - Sustained throughput is one transfer per 4 cycles.
- Each cycle of `PREADY`=0 in ACCESS adds one cycle of latency.
- Simultaneous requests: exactly one grant per arbitration. Every continuously-requesting agent is granted within NREQ transactions.
- Reset asserted mid-transfer aborts immediately with no `req_done`. The aborted requester is not re-serviced unless it re-requests.

## Configuration
- Macro: `APB_ARB_TIMEOUT_EN`.
- **Defined**
  - A counter increments on each ACCESS cycle with `PREADY`=0.
  - When it reaches `TIMEOUT`, the FSM pulses `req_done[winner]` with `req_err`=1 and `req_rdata`=0, deasserts `PSEL` and `transfer`, and goes to DONE.
  - The counter clears on entering ACCESS.
- **Undefined**
  - ACCESS waits indefinitely for `PREADY`, and `req_err` is tied to 0.
  - No counter logic is generated.

## Test plan
- **Reset**: assert `PRESETn`=0 mid-ACCESS -> all outputs 0 asynchronously; state IDLE; no `req_done`.
- **Single write**: requester 1 drives `req_write`=1, `addr`=0x0000_0010, `wdata`=0xDEAD_BEEF, with `PREADY` held 1 -> `req_grant`=4'b0010; `PADDR`/`PDATA` equal the latched values at E; `req_done[1]` pulses at E+2; `PSEL` high for exactly 2 cycles.
- **Read with wait states**: requester 2 reads `addr`=0x20; `PREADY`=0 for 3 ACCESS cycles; `PRDATA`=0x1234_5678 -> `req_done[2]` at E+5 with `req_rdata`=0x1234_5678 and `req_err`=0.
- **Round-robin fairness**: all 4 requesters hold `req_valid` -> grant order 0, 1, 2, 3, 0, with one grant every 4 cycles; `ptr` wraps after 3.
- **Withdrawal and ignore**:
  - Requester 3 drops `req_valid` while requester 0 is in ACCESS -> requester 3 is never granted.
  - Requester 0 changes `req_addr` during its own transfer -> `PADDR` is unchanged.
- **Timeout** (`APB_ARB_TIMEOUT_EN`, `TIMEOUT`=16): hold `PREADY`=0 -> `req_done` with `req_err`=1 and `req_rdata`=0 after 16 ACCESS cycles; the next requester is granted 2 cycles later. Without the macro, the same stimulus keeps the FSM in ACCESS for 100 or more cycles.
